// File: rtl/axis_bram_reader.sv
// axis_bram_reader
//   Streams BRAM contents out on an AXI4-Stream master. It reads addresses
//   0..cfg_data in order. With CONTINUOUS=1 it wraps to 0 and keeps reading.
//   With CONTINUOUS=0 it makes one pass and then stops.
//
//   Every read is issued against a credit. The credit pool is the free space
//   in a 4-entry output FIFO minus the reads still in flight. Because of this,
//   BRAM latency and downstream backpressure never drop or duplicate a word.
//
// Ports
//   aclk, aresetn   clock, asynchronous active-low reset
//   cfg_data        last address of the read window (inclusive), held stable while running
//   sts_data        address of the next word to be accepted on m_axis
//   m_axis_*        AXI4-Stream master (tdata, tvalid, tready, tlast)
//   b_bram_clk/rst  clock and reset forwarded to the BRAM port
//   b_bram_en       read enable, one read per high cycle
//   b_bram_addr     read address
//   b_bram_rdata    read data, valid BRAM_LATENCY cycles after en
module axis_bram_reader #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int BRAM_DATA_WIDTH  = 32,
   parameter int BRAM_ADDR_WIDTH  = 10,
   parameter int BRAM_LATENCY     = 1,
   parameter int CONTINUOUS       = 1
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_data,
   output logic [BRAM_ADDR_WIDTH-1:0]  sts_data,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic                        b_bram_clk,
   output logic                        b_bram_rst,
   output logic                        b_bram_en,
   output logic [BRAM_ADDR_WIDTH-1:0]  b_bram_addr,
   input  logic [BRAM_DATA_WIDTH-1:0]  b_bram_rdata
);

   localparam int FIFO_DEPTH = 4;
   localparam int LAT        = BRAM_LATENCY;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

   state_t                     state_reg, state_next;
   logic [BRAM_ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
   logic [BRAM_ADDR_WIDTH-1:0] out_addr_reg;

   // Each tag stage is {valid, last} for one outstanding BRAM read.
   logic [LAT-1:0]             tag_valid_reg, tag_valid_next;
   logic [LAT-1:0]             tag_last_reg, tag_last_next;

   logic [BRAM_DATA_WIDTH-1:0] fifo_data_reg [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]      fifo_last_reg;
   logic [1:0]                 wr_ptr_reg, rd_ptr_reg;
   logic [2:0]                 fifo_count_reg;

   logic [2:0]                 in_flight;
   logic                       credit_ok;
   logic                       addr_is_last;
   logic                       issue;
   logic                       fifo_wr;
   logic                       fifo_pop;

   assign b_bram_clk = aclk;
   assign b_bram_rst = ~aresetn;

   // Reads still travelling through the BRAM pipeline.
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < LAT; i++) begin
         in_flight = in_flight + {2'b00, tag_valid_reg[i]};
      end
   end

   // A read may issue only if its word is guaranteed a FIFO slot on arrival.
   // The pop of this cycle is ignored on purpose. This keeps the credit path
   // independent of m_axis_tready and still sustains one word per cycle.
   assign credit_ok    = ({1'b0, fifo_count_reg} + {1'b0, in_flight}) < 4'd4;
   assign addr_is_last = (rd_addr_reg == cfg_data);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg <= ST_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      if ((state_reg == ST_RUN) && issue && addr_is_last && (CONTINUOUS == 0)) begin
         state_next = ST_DONE;
      end
   end

   // ---------------- FSM: outputs ----------------
   // The enable is gated by aresetn. This keeps en low for the whole time
   // reset is held, not only after the first edge.
   always_comb begin
      issue = 1'b0;
      if ((state_reg == ST_RUN) && credit_ok && aresetn) begin
         issue = 1'b1;
      end
   end

   assign b_bram_en   = issue;
   assign b_bram_addr = rd_addr_reg;

   // Read address: wrap after the last address of the window. cfg_data is
   // compared live, so a lowered window runs on to all-ones before wrapping.
   always_comb begin
      rd_addr_next = rd_addr_reg;
      if (issue) begin
         rd_addr_next = addr_is_last ? '0 : rd_addr_reg + BRAM_ADDR_WIDTH'(1);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_addr_reg <= '0;
      end else begin
         rd_addr_reg <= rd_addr_next;
      end
   end

   // Tag pipeline, one stage per cycle of BRAM latency.
   generate
      for (genvar gi = 0; gi < LAT; gi++) begin : g_tag
         if (gi == 0) begin : g_head
            assign tag_valid_next[gi] = issue;
            assign tag_last_next[gi]  = issue & addr_is_last;
         end else begin : g_shift
            assign tag_valid_next[gi] = tag_valid_reg[gi-1];
            assign tag_last_next[gi]  = tag_last_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tag_valid_reg <= '0;
         tag_last_reg  <= '0;
      end else begin
         tag_valid_reg <= tag_valid_next;
         tag_last_reg  <= tag_last_next;
      end
   end

   // rdata is captured only on the edge where its tag leaves the pipeline.
   // The credit check guarantees this write always finds room.
   assign fifo_wr  = tag_valid_reg[LAT-1];
   assign fifo_pop = m_axis_tvalid & m_axis_tready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
         fifo_last_reg  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_reg[i] <= '0;
         end
      end else begin
         if (fifo_wr) begin
            fifo_data_reg[wr_ptr_reg] <= b_bram_rdata;
            fifo_last_reg[wr_ptr_reg] <= tag_last_reg[LAT-1];
            wr_ptr_reg                <= wr_ptr_reg + 2'd1;
         end
         if (fifo_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 2'd1;
         end
         case ({fifo_wr, fifo_pop})
            2'b10:   fifo_count_reg <= fifo_count_reg + 3'd1;
            2'b01:   fifo_count_reg <= fifo_count_reg - 3'd1;
            default: fifo_count_reg <= fifo_count_reg;
         endcase
      end
   end

   // The FIFO head is a register. It holds while stalled because rd_ptr
   // moves only on a pop.
   assign m_axis_tvalid = (fifo_count_reg != 3'd0);
   assign m_axis_tdata  = fifo_data_reg[rd_ptr_reg];
   assign m_axis_tlast  = fifo_last_reg[rd_ptr_reg] & m_axis_tvalid;

   // Output position follows the accepted words. It wraps on the tlast word,
   // so it stays consistent with the read side.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_addr_reg <= '0;
      end else if (fifo_pop) begin
         out_addr_reg <= m_axis_tlast ? '0 : out_addr_reg + BRAM_ADDR_WIDTH'(1);
      end
   end

   assign sts_data = out_addr_reg;

endmodule

// File: tb/tb_axis_bram_reader.sv
`timescale 1ns/1ps
// Four readers run side by side from one shared stimulus:
//   dut0: latency 1, continuous    dut1: latency 2, continuous
//   dut2: latency 1, one pass      dut3: latency 2, one pass
// The reference model states the expected stream directly from the word
// count: word n comes from address n mod (cfg+1).
module tb_axis_bram_reader;

   localparam int NDUT = 4;
   localparam int AW   = 10;
   localparam int DW   = 32;

   logic          clk      = 1'b0;
   logic          aresetn  = 1'b1;
   logic [AW-1:0] cfg_data = 10'd7;
   logic          tready   = 1'b0;

   logic [AW-1:0] sts   [NDUT];
   logic [DW-1:0] tdata [NDUT];
   logic          tvalid[NDUT];
   logic          tlast [NDUT];
   logic          bclk  [NDUT];
   logic          brst  [NDUT];
   logic          en    [NDUT];
   logic [AW-1:0] addr  [NDUT];
   logic [DW-1:0] rdata [NDUT];

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] bram_val(input int a);
      return 32'hA500_0000 | 32'(a);
   endfunction

   function automatic int lat_of(input int k);
      return (k % 2) + 1;
   endfunction

   function automatic bit cont_of(input int k);
      return (k < 2);
   endfunction

   generate
      for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
         logic [DW-1:0] pipe1, pipe2;

         axis_bram_reader #(
            .AXIS_TDATA_WIDTH(DW),
            .BRAM_DATA_WIDTH (DW),
            .BRAM_ADDR_WIDTH (AW),
            .BRAM_LATENCY    ((gi % 2) + 1),
            .CONTINUOUS      ((gi < 2) ? 1 : 0)
         ) u_dut (
            .aclk         (clk),
            .aresetn      (aresetn),
            .cfg_data     (cfg_data),
            .sts_data     (sts[gi]),
            .m_axis_tdata (tdata[gi]),
            .m_axis_tvalid(tvalid[gi]),
            .m_axis_tready(tready),
            .m_axis_tlast (tlast[gi]),
            .b_bram_clk   (bclk[gi]),
            .b_bram_rst   (brst[gi]),
            .b_bram_en    (en[gi]),
            .b_bram_addr  (addr[gi]),
            .b_bram_rdata (rdata[gi])
         );

         // BRAM model: the data is valid 1 or 2 cycles after en.
         // Garbage appears whenever no read was made.
         always @(posedge clk) begin
            pipe1 <= en[gi] ? bram_val(int'(addr[gi])) : 32'hDEAD_BEEF;
            pipe2 <= pipe1;
         end
         assign rdata[gi] = ((gi % 2) == 0) ? pipe1 : pipe2;
      end
   endgenerate

   // ---------------- model state and checking ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   bit          gap_chk = 1'b0;
   int          acc      [NDUT];
   int          iss      [NDUT];
   int          t_iss    [NDUT];
   bit          seen_iss [NDUT];
   bit          seen_val [NDUT];
   bit          stalled  [NDUT];
   logic [DW-1:0] prev_data[NDUT];
   logic        prev_last[NDUT];

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s dut%0d: got 0x%0h, want 0x%0h (t=%0t)", name, k, act, exp, $time);
      end
   endtask

   // Called at the falling edge. The values seen here are the ones the DUT
   // acts on at the next rising edge.
   task automatic monitor();
      int cfgp1;
      int pos;
      cyc++;
      cfgp1 = int'(cfg_data) + 1;
      for (int k = 0; k < NDUT; k++) begin
         if (!aresetn) begin
            acc[k] = 0; iss[k] = 0; seen_iss[k] = 0; seen_val[k] = 0; stalled[k] = 0;
         end else begin
            if (stalled[k]) begin
               chk("stall_valid", k, 32'(tvalid[k]), 32'd1);
               chk("stall_data", k, tdata[k], prev_data[k]);
               chk("stall_last", k, 32'(tlast[k]), 32'(prev_last[k]));
            end
            if (tvalid[k] && !seen_val[k]) begin
               seen_val[k] = 1;
               chk("first_latency", k, 32'(cyc - t_iss[k]), 32'(lat_of(k) + 1));
            end
            if (gap_chk && cont_of(k) && seen_val[k]) begin
               chk("no_gap", k, 32'(tvalid[k]), 32'd1);
            end
            chk("sts_data", k, 32'(sts[k]), 32'(acc[k] % cfgp1));
            if (en[k]) begin
               chk("credit_limit", k, 32'((iss[k] - acc[k] + 1) <= 4), 32'd1);
               chk("rd_addr", k, 32'(addr[k]), 32'(iss[k] % cfgp1));
               if (!cont_of(k)) chk("onepass_reads", k, 32'(iss[k] < cfgp1), 32'd1);
               if (!seen_iss[k]) begin
                  seen_iss[k] = 1;
                  t_iss[k]    = cyc;
               end
               iss[k]++;
            end
            if (tvalid[k] && tready) begin
               pos = acc[k] % cfgp1;
               if (!cont_of(k)) chk("onepass_words", k, 32'(acc[k] < cfgp1), 32'd1);
               chk("tdata", k, tdata[k], bram_val(pos));
               chk("tlast", k, 32'(tlast[k]), 32'(pos == cfgp1 - 1));
               $display("[TB] dut%0d word %0d addr %0d data %08h last %0d",
                        k, acc[k], pos, tdata[k], tlast[k]);
               acc[k]++;
            end
            stalled[k]   = tvalid[k] && !tready;
            prev_data[k] = tdata[k];
            prev_last[k] = tlast[k];
         end
      end
   endtask

   // Entered and left at posedge+2ns.
   task automatic cycle(input logic rdy);
      tready = rdy;
      @(negedge clk);
      monitor();
      @(posedge clk);
      #2;
   endtask

   // Asserts reset, checks the asynchronous reset values, holds reset for
   // two cycles and then releases it.
   task automatic do_reset(input int cfg);
      gap_chk  = 1'b0;
      aresetn  = 1'b0;
      cfg_data = AW'(cfg);
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk("rst_tvalid", k, 32'(tvalid[k]), 32'd0);
         chk("rst_tlast", k, 32'(tlast[k]), 32'd0);
         chk("rst_tdata", k, tdata[k], 32'd0);
         chk("rst_en", k, 32'(en[k]), 32'd0);
         chk("rst_sts", k, 32'(sts[k]), 32'd0);
         chk("rst_bram_rst", k, 32'(brst[k]), 32'd1);
         chk("bram_clk", k, 32'(bclk[k]), 32'(clk));
      end
      cycle(1'b0);
      cycle(1'b0);
      aresetn = 1'b1;
   endtask

   typedef struct {
      bit do_rst;
      int cfg;
      int rdy_pct;
      int ncyc;
      int exp_iss_c;   // continuous readers' total issues, -1 = not checked
      int exp_iss_o;   // one-pass readers' total issues
      int exp_acc_o;   // one-pass readers' total accepted words
   } phase_t;

   phase_t ph [7];

   initial begin
      ph[0] = '{1'b1, 7, 100,  60, -1, 8, 8};  // back-to-back window 0..7
      ph[1] = '{1'b1, 7,  50, 150, -1, 8, 8};  // random backpressure
      ph[2] = '{1'b1, 0, 100,  30, -1, 1, 1};  // single-word window
      ph[3] = '{1'b1, 7,   0,  20,  4, 4, 0};  // long stall: only 4 reads
      ph[4] = '{1'b0, 7, 100,  40, -1, 8, 8};  // release, order resumes at 0
      ph[5] = '{1'b1, 5,  70, 100, -1, 6, 6};
      ph[6] = '{1'b1, 2,  30, 100, -1, 3, 3};

      for (int k = 0; k < NDUT; k++) begin
         acc[k] = 0; iss[k] = 0; t_iss[k] = 0;
         seen_iss[k] = 0; seen_val[k] = 0; stalled[k] = 0;
         prev_data[k] = '0; prev_last[k] = 1'b0;
      end

      @(posedge clk);
      #2;

      for (int p = 0; p < 7; p++) begin
         if (ph[p].do_rst) do_reset(ph[p].cfg);
         gap_chk = (ph[p].rdy_pct == 100) && ph[p].do_rst;
         for (int c = 0; c < ph[p].ncyc; c++) begin
            cycle($urandom_range(99) < ph[p].rdy_pct);
         end
         gap_chk = 1'b0;
         for (int k = 0; k < NDUT; k++) begin
            if (cont_of(k)) begin
               if (ph[p].exp_iss_c >= 0) chk("phase_issues", k, 32'(iss[k]), 32'(ph[p].exp_iss_c));
               if (ph[p].rdy_pct > 0) chk("phase_progress", k, 32'(acc[k] > 0), 32'd1);
            end else begin
               chk("phase_issues", k, 32'(iss[k]), 32'(ph[p].exp_iss_o));
               chk("phase_words", k, 32'(acc[k]), 32'(ph[p].exp_acc_o));
            end
         end
      end

      // Reset in the middle of a stream, after word 5 of dut0.
      do_reset(7);
      gap_chk = 1'b1;
      for (int c = 0; c < 60 && acc[0] < 6; c++) cycle(1'b1);
      chk("reach_word5", 0, 32'(acc[0] >= 6), 32'd1);
      do_reset(7);
      gap_chk = 1'b1;
      for (int c = 0; c < 40; c++) cycle(1'b1);
      gap_chk = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         chk("restart_words", k, 32'(acc[k] >= 8), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
